// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory-stage access engine: size codes, mem_ctrl bit
// positions, FSM states and the alignment rule.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_WORD  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_BYTE  = 2'b10;
  localparam logic [1:0] SZ_BYTEU = 2'b11;

  localparam int unsigned MC_READ   = 0;
  localparam int unsigned MC_WRITE  = 1;
  localparam int unsigned MC_BRANCH = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_WORD: ok = (addr_lo == 2'b00);
      SZ_HALF: ok = (addr_lo[0] == 1'b0);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Lane offset actually used: halves ignore addr[0], words always start at lane 0.
  function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [1:0] off;
    case (size)
      SZ_WORD: off = 2'b00;
      SZ_HALF: off = {addr_lo[1], 1'b0};
      default: off = addr_lo;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: byte enables and store replication for the request side,
// lane extraction and sign/zero extension for the load side.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic [1:0]  st_off_s;
  logic [1:0]  ld_off_s;
  logic [31:0] shifted_s;

  assign st_off_s  = lane_off(size_i, addr_lo_i);
  assign ld_off_s  = lane_off(ld_size_i, ld_addr_lo_i);
  assign shifted_s = rdata_i >> {ld_off_s, 3'b000};

  // Request-side enables and replicated store data.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0000_0000;
    case (size_i)
      SZ_WORD: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << st_off_s;
        wdata_o = {2{wdata_i[15:0]}};
      end
      SZ_BYTE, SZ_BYTEU: begin
        be_o    = 4'b0001 << st_off_s;
        wdata_o = {4{wdata_i[7:0]}};
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = 32'h0000_0000;
      end
    endcase
  end

  // Load-side extraction from the lane recorded with the request.
  always_comb begin
    rdata_o = 32'h0000_0000;
    case (ld_size_i)
      SZ_WORD:  rdata_o = rdata_i;
      SZ_HALF:  rdata_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
      SZ_BYTE:  rdata_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
      SZ_BYTEU: rdata_o = {24'h00_0000, shifted_s[7:0]};
      default:  rdata_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage req/ack engine with stall and load extraction.
// Define MEM_ALIGN_EXC_EN to trap misaligned accesses instead of issuing them.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter bit IDLE_ON_RESET = 1'b1
)
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [2:0]  mem_ctrl_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        exc_align_o,
  output logic [31:0] exc_addr_o
);

  state_e      state_q, state_d;
  logic        req_s, is_write_s, aligned_s, stall_s, rst_active_s;
  logic        unused_branch_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_rep_s, ld_data_s;

  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic [1:0]  ld_lo_q, ld_lo_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;

  assign req_s           = mem_ctrl_i[MC_READ] | mem_ctrl_i[MC_WRITE];
  assign is_write_s      = mem_ctrl_i[MC_WRITE];
  assign unused_branch_s = mem_ctrl_i[MC_BRANCH];
  assign rst_active_s    = ~RESET & IDLE_ON_RESET;

`ifdef MEM_ALIGN_EXC_EN
  logic        exc_align_q, exc_align_d;
  logic [31:0] exc_addr_q, exc_addr_d;
  assign aligned_s = is_aligned(size_i, addr_i[1:0]);
`else
  assign aligned_s = 1'b1;
`endif

  mem_lane_align u_lane (
    .size_i       (size_i),
    .addr_lo_i    (addr_i[1:0]),
    .wdata_i      (wdata_i),
    .be_o         (be_s),
    .wdata_o      (wdata_rep_s),
    .ld_size_i    (ld_size_q),
    .ld_addr_lo_i (ld_lo_q),
    .rdata_i      (bus_rdata_i),
    .rdata_o      (ld_data_s)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s && aligned_s) state_d = ST_BUSY;
        else                    state_d = ST_IDLE;
      end
      ST_BUSY: begin
        if (bus_ack_i) state_d = ST_IDLE;
        else           state_d = ST_BUSY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: stall plus next values of the registered bus and result outputs.
  always_comb begin
    stall_s       = 1'b0;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_be_d      = bus_be_q;
    bus_wdata_d   = bus_wdata_q;
    ld_size_d     = ld_size_q;
    ld_lo_d       = ld_lo_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
`ifdef MEM_ALIGN_EXC_EN
    exc_align_d   = 1'b0;
    exc_addr_d    = exc_addr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_s && aligned_s) begin
          stall_s     = 1'b1;
          bus_req_d   = 1'b1;
          bus_we_d    = is_write_s;
          bus_addr_d  = {addr_i[31:2], 2'b00};
          bus_be_d    = be_s;
          bus_wdata_d = wdata_rep_s;
          ld_size_d   = size_i;
          ld_lo_d     = addr_i[1:0];
`ifdef MEM_ALIGN_EXC_EN
        end else if (req_s) begin
          exc_align_d = 1'b1;
          exc_addr_d  = addr_i;
`endif
        end else begin
          bus_req_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (bus_ack_i) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            rdata_valid_d = 1'b1;
            rdata_d       = ld_data_s;
          end else begin
            rdata_valid_d = 1'b0;
          end
        end else begin
          stall_s   = 1'b1;
          bus_req_d = 1'b1;
        end
      end
      default: begin
        stall_s   = 1'b0;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // Registered outputs, cleared asynchronously so an abandoned access vanishes at once.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= 32'h0000_0000;
      bus_be_q      <= 4'b0000;
      bus_wdata_q   <= 32'h0000_0000;
      ld_size_q     <= SZ_WORD;
      ld_lo_q       <= 2'b00;
      rdata_q       <= 32'h0000_0000;
      rdata_valid_q <= 1'b0;
    end else begin
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_be_q      <= bus_be_d;
      bus_wdata_q   <= bus_wdata_d;
      ld_size_q     <= ld_size_d;
      ld_lo_q       <= ld_lo_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

`ifdef MEM_ALIGN_EXC_EN
  // Misalignment exception registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      exc_align_q <= 1'b0;
      exc_addr_q  <= 32'h0000_0000;
    end else begin
      exc_align_q <= exc_align_d;
      exc_addr_q  <= exc_addr_d;
    end
  end
  assign exc_align_o = exc_align_q;
  assign exc_addr_o  = exc_addr_q;
`else
  assign exc_align_o = 1'b0;
  assign exc_addr_o  = 32'h0000_0000;
`endif

  assign bus_req_o     = bus_req_q;
  assign bus_we_o      = bus_we_q;
  assign bus_addr_o    = bus_addr_q;
  assign bus_be_o      = bus_be_q;
  assign bus_wdata_o   = bus_wdata_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign stall_o       = ~rst_active_s & stall_s;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (honours MEM_ALIGN_EXC_EN).
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [2:0]  mem_ctrl_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i, bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_req_o, bus_we_o, stall_o, rdata_valid_o, exc_align_o;
  logic [31:0] bus_addr_o, bus_wdata_o, rdata_o, exc_addr_o;
  logic [3:0]  bus_be_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic        obs_req, obs_we, obs_valid, obs_valid2, obs_req_after;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  int          stall_cnt;

  always #5 CLK = ~CLK;

  mem_access_unit dut (
    .CLK(CLK), .RESET(RESET), .mem_ctrl_i(mem_ctrl_i), .size_i(size_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .exc_align_o(exc_align_o), .exc_addr_o(exc_addr_o)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drives one access, holds it while stalled, acks after `waits` BUSY cycles.
  task automatic issue(input logic [2:0] ctrl, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int waits);
    mem_ctrl_i = ctrl; size_i = sz; addr_i = a; wdata_i = wd; bus_rdata_i = rd;
    bus_ack_i = 1'b0; stall_cnt = 0;
    #1;
    if (stall_o) stall_cnt++;
    step();
    obs_req = bus_req_o; obs_we = bus_we_o; obs_be = bus_be_o;
    obs_addr = bus_addr_o; obs_wdata = bus_wdata_o;
    for (int i = 0; i < waits; i++) begin
      if (stall_o) stall_cnt++;
      step();
    end
    bus_ack_i = 1'b1;
    #1;
    if (stall_o) stall_cnt++;
    step();
    bus_ack_i = 1'b0; mem_ctrl_i = 3'b000;
    #1;
    obs_rdata = rdata_o; obs_valid = rdata_valid_o; obs_req_after = bus_req_o;
    step();
    obs_valid2 = rdata_valid_o;
  endtask

  task automatic test_reset();
    RESET = 1'b0; mem_ctrl_i = 3'b000; size_i = 2'b00; addr_i = 32'h0;
    wdata_i = 32'h0; bus_rdata_i = 32'h0; bus_ack_i = 1'b0;
    #12;
    mem_ctrl_i = 3'b001;
    #1;
    n_cmp++; if ({bus_req_o, bus_we_o, bus_be_o, rdata_valid_o, exc_align_o} !== 8'h00) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0", {bus_req_o, bus_we_o, bus_be_o, rdata_valid_o, exc_align_o}); end
    n_cmp++; if ({bus_addr_o, bus_wdata_o, rdata_o, exc_addr_o} !== 128'h0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", {bus_addr_o, bus_wdata_o, rdata_o, exc_addr_o}); end
    n_cmp++; if (stall_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    mem_ctrl_i = 3'b000;
    #8 RESET = 1'b1;
    step();
  endtask

  task automatic test_word_load();
    issue(3'b001, 2'b00, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2);
    n_cmp++; if (obs_req !== 1'b1 || obs_we !== 1'b0) begin
      n_bad++; $display("FAIL wl_req: got req=%b we=%b want req=1 we=0", obs_req, obs_we); end
    n_cmp++; if (obs_be !== 4'b1111 || obs_addr !== 32'h0000_0100) begin
      n_bad++; $display("FAIL wl_bus: got be=%b addr=%h want 1111 00000100", obs_be, obs_addr); end
    n_cmp++; if (stall_cnt != 3) begin
      n_bad++; $display("FAIL wl_stall: got %0d want 3 cycles", stall_cnt); end
    n_cmp++; if (obs_rdata !== 32'hDEAD_BEEF || obs_valid !== 1'b1 || obs_req_after !== 1'b0) begin
      n_bad++; $display("FAIL wl_data: got %h v=%b req=%b want deadbeef v=1 req=0", obs_rdata, obs_valid, obs_req_after); end
    n_cmp++; if (obs_valid2 !== 1'b0 || rdata_o !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL wl_pulse: got v=%b rdata=%h want v=0 deadbeef", obs_valid2, rdata_o); end
  endtask

  task automatic test_byte_load();
    issue(3'b001, 2'b10, 32'h0000_0103, 32'h0, 32'h8000_0000, 0);
    n_cmp++; if (obs_rdata !== 32'hFFFF_FF80 || obs_be !== 4'b1000 || stall_cnt != 1) begin
      n_bad++; $display("FAIL lb_signed: got %h be=%b st=%0d want ffffff80 1000 1", obs_rdata, obs_be, stall_cnt); end
    issue(3'b001, 2'b11, 32'h0000_0103, 32'h0, 32'h8000_0000, 1);
    n_cmp++; if (obs_rdata !== 32'h0000_0080 || obs_valid !== 1'b1) begin
      n_bad++; $display("FAIL lb_unsigned: got %h v=%b want 00000080 v=1", obs_rdata, obs_valid); end
    issue(3'b001, 2'b01, 32'h0000_0102, 32'h0, 32'h8001_1234, 0);
    n_cmp++; if (obs_rdata !== 32'hFFFF_8001 || obs_be !== 4'b1100) begin
      n_bad++; $display("FAIL lh_hi: got %h be=%b want ffff8001 1100", obs_rdata, obs_be); end
    issue(3'b001, 2'b01, 32'h0000_0100, 32'h0, 32'h8001_7FFF, 0);
    n_cmp++; if (obs_rdata !== 32'h0000_7FFF || obs_be !== 4'b0011) begin
      n_bad++; $display("FAIL lh_lo: got %h be=%b want 00007fff 0011", obs_rdata, obs_be); end
  endtask

  task automatic test_store();
    issue(3'b010, 2'b01, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 1);
    n_cmp++; if (obs_be !== 4'b1100 || obs_wdata !== 32'hABCD_ABCD || obs_addr !== 32'h0000_0200 || obs_we !== 1'b1) begin
      n_bad++; $display("FAIL sh: got be=%b wd=%h a=%h we=%b want 1100 abcdabcd 00000200 1", obs_be, obs_wdata, obs_addr, obs_we); end
    n_cmp++; if (obs_valid !== 1'b0) begin
      n_bad++; $display("FAIL sh_valid: got %b want 0", obs_valid); end
    issue(3'b010, 2'b10, 32'h0000_0201, 32'h0000_0055, 32'h0, 0);
    n_cmp++; if (obs_be !== 4'b0010 || obs_wdata !== 32'h5555_5555) begin
      n_bad++; $display("FAIL sb: got be=%b wd=%h want 0010 55555555", obs_be, obs_wdata); end
  endtask

  task automatic test_misalign();
`ifdef MEM_ALIGN_EXC_EN
    mem_ctrl_i = 3'b001; size_i = 2'b00; addr_i = 32'h0000_0101; bus_ack_i = 1'b0;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin
      n_bad++; $display("FAIL ma_stall: got %b want 0", stall_o); end
    step();
    mem_ctrl_i = 3'b000;
    #1;
    n_cmp++; if (exc_align_o !== 1'b1 || exc_addr_o !== 32'h0000_0101 || bus_req_o !== 1'b0) begin
      n_bad++; $display("FAIL ma_exc: got exc=%b a=%h req=%b want 1 00000101 0", exc_align_o, exc_addr_o, bus_req_o); end
    step();
    n_cmp++; if (exc_align_o !== 1'b0 || exc_addr_o !== 32'h0000_0101 || bus_req_o !== 1'b0) begin
      n_bad++; $display("FAIL ma_hold: got exc=%b a=%h req=%b want 0 00000101 0", exc_align_o, exc_addr_o, bus_req_o); end
`else
    issue(3'b001, 2'b00, 32'h0000_0101, 32'h0, 32'h0BAD_F00D, 0);
    n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 32'h0000_0100 || obs_be !== 4'b1111) begin
      n_bad++; $display("FAIL ma_bus: got req=%b a=%h be=%b want 1 00000100 1111", obs_req, obs_addr, obs_be); end
    n_cmp++; if (obs_rdata !== 32'h0BAD_F00D || exc_align_o !== 1'b0 || exc_addr_o !== 32'h0) begin
      n_bad++; $display("FAIL ma_data: got %h exc=%b a=%h want 0badf00d 0 0", obs_rdata, exc_align_o, exc_addr_o); end
    issue(3'b001, 2'b01, 32'h0000_0103, 32'h0, 32'hA5B6_0000, 0);
    n_cmp++; if (obs_be !== 4'b1100 || obs_rdata !== 32'hFFFF_A5B6) begin
      n_bad++; $display("FAIL ma_half: got be=%b d=%h want 1100 ffffa5b6", obs_be, obs_rdata); end
`endif
  endtask

  task automatic test_reset_busy();
    mem_ctrl_i = 3'b001; size_i = 2'b00; addr_i = 32'h0000_0300; bus_ack_i = 1'b0;
    step();
    n_cmp++; if (bus_req_o !== 1'b1 || stall_o !== 1'b1) begin
      n_bad++; $display("FAIL rb_busy: got req=%b stall=%b want 1 1", bus_req_o, stall_o); end
    #2 RESET = 1'b0;
    #1;
    n_cmp++; if (bus_req_o !== 1'b0 || stall_o !== 1'b0 || bus_addr_o !== 32'h0 || bus_be_o !== 4'b0) begin
      n_bad++; $display("FAIL rb_drop: got req=%b stall=%b a=%h be=%b want all 0", bus_req_o, stall_o, bus_addr_o, bus_be_o); end
    mem_ctrl_i = 3'b000;
    #2 RESET = 1'b1;
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222;
    step();
    bus_ack_i = 1'b0;
    n_cmp++; if (bus_req_o !== 1'b0 || rdata_valid_o !== 1'b0 || rdata_o !== 32'h0 || stall_o !== 1'b0) begin
      n_bad++; $display("FAIL rb_late_ack: got req=%b v=%b d=%h st=%b want 0 0 0 0", bus_req_o, rdata_valid_o, rdata_o, stall_o); end
  endtask

  task automatic test_rw_both();
    issue(3'b011, 2'b00, 32'h0000_0010, 32'hCAFE_0001, 32'h7777_7777, 0);
    n_cmp++; if (obs_we !== 1'b1 || obs_addr !== 32'h0000_0010 || obs_wdata !== 32'hCAFE_0001) begin
      n_bad++; $display("FAIL rw_write: got we=%b a=%h wd=%h want 1 00000010 cafe0001", obs_we, obs_addr, obs_wdata); end
    n_cmp++; if (obs_valid !== 1'b0 || obs_valid2 !== 1'b0 || rdata_o === 32'h7777_7777) begin
      n_bad++; $display("FAIL rw_valid: got v=%b/%b d=%h want no load result", obs_valid, obs_valid2, rdata_o); end
  endtask

  task automatic test_back_to_back();
    mem_ctrl_i = 3'b001; size_i = 2'b00; addr_i = 32'h0000_0040; bus_rdata_i = 32'h1122_3344;
    bus_ack_i = 1'b0;
    step();
    bus_ack_i = 1'b1;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin
      n_bad++; $display("FAIL b2b_ackstall: got %b want 0", stall_o); end
    step();
    bus_ack_i = 1'b0; mem_ctrl_i = 3'b010; addr_i = 32'h0000_0044; wdata_i = 32'hCAFE_F00D;
    #1;
    n_cmp++; if (rdata_o !== 32'h1122_3344 || rdata_valid_o !== 1'b1 || stall_o !== 1'b1) begin
      n_bad++; $display("FAIL b2b_first: got d=%h v=%b st=%b want 11223344 1 1", rdata_o, rdata_valid_o, stall_o); end
    step();
    n_cmp++; if (bus_req_o !== 1'b1 || bus_we_o !== 1'b1 || bus_addr_o !== 32'h0000_0044 || rdata_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL b2b_second: got req=%b we=%b a=%h v=%b want 1 1 00000044 0", bus_req_o, bus_we_o, bus_addr_o, rdata_valid_o); end
    bus_ack_i = 1'b1;
    step();
    bus_ack_i = 1'b0; mem_ctrl_i = 3'b000;
    #1;
    n_cmp++; if (bus_req_o !== 1'b0 || rdata_valid_o !== 1'b0 || bus_wdata_o !== 32'hCAFE_F00D) begin
      n_bad++; $display("FAIL b2b_done: got req=%b v=%b wd=%h want 0 0 cafef00d", bus_req_o, rdata_valid_o, bus_wdata_o); end
  endtask

  task automatic test_idle_ack();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h9999_9999;
    step();
    bus_ack_i = 1'b0;
    n_cmp++; if (rdata_valid_o !== 1'b0 || bus_req_o !== 1'b0 || rdata_o !== 32'h1122_3344) begin
      n_bad++; $display("FAIL idle_ack: got v=%b req=%b d=%h want 0 0 11223344", rdata_valid_o, bus_req_o, rdata_o); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_store();
    test_misalign();
    test_reset_busy();
    test_rw_both();
    test_back_to_back();
    test_idle_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
